// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI load-command receiver.
// Latency: none (declarations only).
// Backpressure: none.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        ARRANCA,
        ESPERA
    } estado_t;

    localparam logic [3:0] TRAMA_BITS    = 4'd8;
    localparam logic [3:0] CMD_CARGA_DEF = 4'hA;

endpackage

// File: rtl/spi_rx_sincronizador.sv
// Multi-flop synchronizer for one asynchronous input, with edge strobes.
// Latency: SYNC_STAGES clk cycles to q; sube/baja are combinational on q.
// Backpressure: none; edges are one-cycle strobes.
module spi_rx_sincronizador #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic sube,
    output logic baja
);

    logic [SYNC_STAGES-1:0] cadena;
    logic                   previo;

    // Chain resets low so a line already low at reset release never fakes a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cadena <= '0;
            previo <= 1'b0;
        end else begin
            cadena <= {cadena[SYNC_STAGES-2:0], d};
            previo <= cadena[SYNC_STAGES-1];
        end
    end

    assign q    = cadena[SYNC_STAGES-1];
    assign sube = q & ~previo;
    assign baja = ~q & previo;

endmodule

// File: rtl/spi_rx_carga.sv
// SPI mode-0 slave that validates 8-bit load frames and starts the countdown counter.
// Latency: cs_n rise to inicio is SYNC_STAGES+3 clk; rejection flagged after SYNC_STAGES+2.
// Backpressure: frames arriving while ocupado are dropped and flagged; SPI_RX_PARIDAD_EN adds even parity.
module spi_rx_carga
    import spi_rx_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [3:0] CMD_CARGA   = CMD_CARGA_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    input  logic       fin,
    output logic [3:0] datos,
    output logic       inicio,
    output logic       ocupado,
    output logic       error_trama
);

    logic sclk_nivel, sclk_sube, sclk_baja;
    logic cs_nivel, cs_sube, cs_baja;
    logic [SYNC_STAGES-1:0] mosi_cadena;
    logic mosi_s;
    logic unused_ok;

    spi_rx_sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk  (clk),
        .rst  (rst),
        .d    (sclk),
        .q    (sclk_nivel),
        .sube (sclk_sube),
        .baja (sclk_baja)
    );

    spi_rx_sincronizador #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk  (clk),
        .rst  (rst),
        .d    (cs_n),
        .q    (cs_nivel),
        .sube (cs_sube),
        .baja (cs_baja)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_cadena <= '0;
        end else begin
            mosi_cadena <= {mosi_cadena[SYNC_STAGES-2:0], mosi};
        end
    end

    assign mosi_s    = mosi_cadena[SYNC_STAGES-1];
    assign unused_ok = ^{sclk_nivel, sclk_baja};

    logic [7:0] rx_byte;
    logic [3:0] bitcnt;
    logic       activo;
    logic       trama_lista;

    // activo only sets on a real falling edge, so a frame cut by reset is ignored to its end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_byte     <= '0;
            bitcnt      <= '0;
            activo      <= 1'b0;
            trama_lista <= 1'b0;
        end else begin
            trama_lista <= cs_sube & activo;
            if (cs_baja) begin
                rx_byte <= '0;
                bitcnt  <= '0;
                activo  <= 1'b1;
            end else if (cs_sube) begin
                activo  <= 1'b0;
            end else if (sclk_sube && activo && !cs_nivel) begin
                rx_byte <= {rx_byte[6:0], mosi_s};
                if (bitcnt != 4'hF) begin
                    bitcnt <= bitcnt + 4'd1;
                end
            end
        end
    end

    logic cmd_ok;
    logic trama_ok;

`ifdef SPI_RX_PARIDAD_EN
    assign cmd_ok = (rx_byte[7:5] == CMD_CARGA[3:1]) && !(^rx_byte);
`else
    assign cmd_ok = (rx_byte[7:4] == CMD_CARGA);
`endif

    assign trama_ok = (bitcnt == TRAMA_BITS) && cmd_ok && (rx_byte[3:0] != 4'h0);

    estado_t    estado, estado_sig;
    logic       valida;
    logic [3:0] valor;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:    if (trama_lista) estado_sig = CHECK;
            CHECK:   estado_sig = valida ? ARRANCA : IDLE;
            ARRANCA: estado_sig = ESPERA;
            ESPERA:  if (fin) estado_sig = IDLE;
            default: estado_sig = IDLE;
        endcase
    end

    // Verdict is latched with the frame; any frame not landing in IDLE is a busy reject.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valida      <= 1'b0;
            valor       <= '0;
            datos       <= '0;
            error_trama <= 1'b0;
        end else begin
            if (trama_lista) begin
                valida <= trama_ok;
                valor  <= rx_byte[3:0];
            end
            if (estado == CHECK && valida) begin
                datos <= valor;
            end
            if (cs_baja) begin
                error_trama <= 1'b0;
            end else if (trama_lista && (estado != IDLE || !trama_ok)) begin
                error_trama <= 1'b1;
            end
        end
    end

    assign inicio  = (estado == ARRANCA);
    assign ocupado = (estado == ARRANCA) || (estado == ESPERA);

endmodule

// File: tb/tb_spi_rx_carga.sv
// Directed bench for spi_rx_carga with a scoreboard monitor on inicio / error_trama.
// Build with SPI_RX_PARIDAD_EN defined to exercise the parity variant.
module tb_spi_rx_carga;

    logic       clk = 1'b0;
    logic       rst, sclk, cs_n, mosi, fin;
    logic [3:0] datos;
    logic       inicio, ocupado, error_trama;

    typedef struct packed {
        logic       acepta;
        logic [3:0] valor;
    } esperado_t;

    esperado_t cola[$];
    int errores = 0;
    int chequeos = 0;

`ifdef SPI_RX_PARIDAD_EN
    localparam logic [7:0] SEGUNDO = 8'hB2;
`else
    localparam logic [7:0] SEGUNDO = 8'hA2;
`endif

    spi_rx_carga dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .cs_n        (cs_n),
        .mosi        (mosi),
        .fin         (fin),
        .datos       (datos),
        .inicio      (inicio),
        .ocupado     (ocupado),
        .error_trama (error_trama)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
        chequeos++;
        if (act !== req) begin
            errores++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, req, $time);
        end
    endtask

    // Monitor: every inicio or new error_trama consumes one expected outcome.
    logic       prev_inicio = 1'b0, prev_err = 1'b0, prev_ocup = 1'b0;
    logic [3:0] prev_datos = 4'h0;
    always @(negedge clk) begin
        if (rst) begin
            prev_inicio = 1'b0;
            prev_err    = 1'b0;
            prev_ocup   = 1'b0;
            prev_datos  = 4'h0;
        end else begin
            if (inicio) begin
                chk("inicio_no_consecutivo", {31'd0, prev_inicio}, 32'd0);
                chk("ocupado_con_inicio", {31'd0, ocupado}, 32'd1);
                if (cola.size() == 0) begin
                    chk("inicio_inesperado", 32'd1, 32'd0);
                end else begin
                    esperado_t e;
                    e = cola.pop_front();
                    chk("tipo_aceptada", {31'd0, e.acepta}, 32'd1);
                    chk("datos_en_inicio", {28'd0, datos}, {28'd0, e.valor});
                end
            end
            if (error_trama && !prev_err) begin
                if (cola.size() == 0) begin
                    chk("error_inesperado", 32'd1, 32'd0);
                end else begin
                    esperado_t e;
                    e = cola.pop_front();
                    chk("tipo_rechazada", {31'd0, e.acepta}, 32'd0);
                end
            end
            if (ocupado && prev_ocup) begin
                chk("datos_estable_ocupado", {28'd0, datos}, {28'd0, prev_datos});
            end
            prev_inicio = inicio;
            prev_err    = error_trama;
            prev_ocup   = ocupado;
            prev_datos  = datos;
        end
    end

    task automatic bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            #40 sclk = 1'b1;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic trama_cuerpo(input logic [15:0] v, input int n);
        cs_n = 1'b0;
        #80;
        bits(v, n);
        #80;
    endtask

    task automatic cs_alto();
        @(posedge clk);
        #1 cs_n = 1'b1;
    endtask

    task automatic asentar();
        repeat (14) @(posedge clk);
        #1;
    endtask

    task automatic trama(input logic [15:0] v, input int n, input logic acepta, input logic [3:0] val);
        cola.push_back('{acepta: acepta, valor: val});
        trama_cuerpo(v, n);
        cs_alto();
        asentar();
    endtask

    // Counts clk edges from the cs_n rise until inicio (sel=0) or error_trama (sel=1).
    task automatic medir(input logic sel, output int n);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1 n++;
            if (sel ? error_trama : inicio) break;
        end
    endtask

    task automatic pulso_fin();
        @(posedge clk);
        #1 fin = 1'b1;
        chk("ocupado_antes_fin", {31'd0, ocupado}, 32'd1);
        @(posedge clk);
        #1 fin = 1'b0;
        chk("ocupado_tras_fin", {31'd0, ocupado}, 32'd0);
        asentar();
    endtask

    int lat;

    initial begin
        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; fin = 1'b0;
        #23;
        chk("rst_datos", {28'd0, datos}, 32'd0);
        chk("rst_inicio", {31'd0, inicio}, 32'd0);
        chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
        chk("rst_error", {31'd0, error_trama}, 32'd0);
        rst = 1'b0;
        asentar();

        // Good frame with start latency measurement
        cola.push_back('{acepta: 1'b1, valor: 4'h5});
        trama_cuerpo(16'h00A5, 8);
        cs_alto();
        medir(1'b0, lat);
        chk("latencia_inicio", lat, 32'd5);
        asentar();
        chk("a5_datos", {28'd0, datos}, 32'h5);
        chk("a5_ocupado", {31'd0, ocupado}, 32'd1);
        pulso_fin();

        // Bad command with rejection latency measurement
        cola.push_back('{acepta: 1'b0, valor: 4'h0});
        trama_cuerpo(16'h00B3, 8);
        cs_alto();
        medir(1'b1, lat);
        chk("latencia_error", lat, 32'd4);
        asentar();
        chk("b3_datos", {28'd0, datos}, 32'h5);

        trama(16'h00A0, 8, 1'b0, 4'h0);
        chk("a0_datos", {28'd0, datos}, 32'h5);
        chk("a0_error", {31'd0, error_trama}, 32'd1);

        trama(16'h0055, 7, 1'b0, 4'h0);
        chk("corta_error", {31'd0, error_trama}, 32'd1);
        trama(16'h00A5, 9, 1'b0, 4'h0);
        chk("larga_error", {31'd0, error_trama}, 32'd1);
        chk("larga_datos", {28'd0, datos}, 32'h5);

        trama({8'h00, SEGUNDO}, 8, 1'b1, 4'h2);
        chk("segundo_error_limpio", {31'd0, error_trama}, 32'd0);
        chk("segundo_datos", {28'd0, datos}, 32'h2);
        chk("segundo_ocupado", {31'd0, ocupado}, 32'd1);

        // Busy reject without fin
        trama(16'h00A7, 8, 1'b0, 4'h0);
        chk("ocupado_datos", {28'd0, datos}, 32'h2);
        chk("ocupado_sigue", {31'd0, ocupado}, 32'd1);

        // Busy reject with fin landing on the same cycle as the frame
        cola.push_back('{acepta: 1'b0, valor: 4'h0});
        trama_cuerpo(16'h00A7, 8);
        cs_alto();
        repeat (3) @(posedge clk);
        #1 fin = 1'b1;
        @(posedge clk);
        #1 fin = 1'b0;
        asentar();
        chk("coinc_ocupado", {31'd0, ocupado}, 32'd0);
        chk("coinc_error", {31'd0, error_trama}, 32'd1);
        chk("coinc_datos", {28'd0, datos}, 32'h2);

        trama(16'h00A9, 8, 1'b1, 4'h9);
        chk("a9_datos", {28'd0, datos}, 32'h9);
        pulso_fin();
        trama(16'h00B9, 8, 1'b0, 4'h0);
        chk("b9_datos", {28'd0, datos}, 32'h9);

        // Reset in the middle of a frame
        cs_n = 1'b0;
        #80;
        bits(16'h000A, 4);
        #3 rst = 1'b1;
        #20;
        chk("rstmid_datos", {28'd0, datos}, 32'd0);
        chk("rstmid_error", {31'd0, error_trama}, 32'd0);
        chk("rstmid_ocupado", {31'd0, ocupado}, 32'd0);
        rst = 1'b0;
        bits(16'h0005, 4);
        #80;
        cs_alto();
        asentar();
        chk("rstmid_error_final", {31'd0, error_trama}, 32'd0);
        chk("rstmid_inicio", {31'd0, ocupado}, 32'd0);

        trama(16'h00A5, 8, 1'b1, 4'h5);
        chk("recupera_datos", {28'd0, datos}, 32'h5);
        pulso_fin();

        chk("cola_vacia", cola.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errores, chequeos);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
